// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - signed MAC partial-sum accumulator with saturation and ready/valid handshakes
module psum_accumulator #(
  parameter int PARAM_BIT   = 8,
  parameter int PARTIAL_BIT = 25,
  parameter int CNT_BIT     = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_BIT-1:0]     num_terms,
  input  logic [PARTIAL_BIT-1:0] bias,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PARAM_BIT-1:0]   act_in,
  input  logic [PARAM_BIT-1:0]   weight_in,
  output logic [PARTIAL_BIT-1:0] psum_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int PROD_BIT = 2 * PARAM_BIT;
  localparam int EXT_BIT  = PARTIAL_BIT + 1 - PROD_BIT;

  localparam logic [PARTIAL_BIT-1:0] SAT_MAX = {1'b0, {(PARTIAL_BIT-1){1'b1}}};
  localparam logic [PARTIAL_BIT-1:0] SAT_MIN = {1'b1, {(PARTIAL_BIT-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state, state_d;
  logic [PARTIAL_BIT-1:0] acc, acc_d;
  logic [CNT_BIT-1:0]     cnt, cnt_d;
  logic [CNT_BIT-1:0]     n_terms, n_terms_d;

  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic busy_q, busy_d;

  logic [PROD_BIT-1:0]    product;
  logic [PARTIAL_BIT:0]   product_ext;
  logic [PARTIAL_BIT:0]   sum_ext;
  logic [PARTIAL_BIT-1:0] sum_sat;
  logic                   last_term;

  // One guard bit above the accumulator exposes overflow as a mismatch of the top two bits.
  assign product     = PROD_BIT'($signed(act_in) * $signed(weight_in));
  assign product_ext = {{EXT_BIT{product[PROD_BIT-1]}}, product};
  assign sum_ext     = {acc[PARTIAL_BIT-1], acc} + product_ext;

  always_comb begin
    sum_sat = sum_ext[PARTIAL_BIT-1:0];
    if (sum_ext[PARTIAL_BIT] != sum_ext[PARTIAL_BIT-1]) begin
      sum_sat = sum_ext[PARTIAL_BIT] ? SAT_MIN : SAT_MAX;
    end
  end

  // Widened compare so a count of all-ones never wraps back to zero.
  assign last_term = ({1'b0, cnt} + (CNT_BIT+1)'(1)) == {1'b0, n_terms};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      n_terms     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_d;
      acc         <= acc_d;
      cnt         <= cnt_d;
      n_terms     <= n_terms_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d   = state;
    acc_d     = acc;
    cnt_d     = cnt;
    n_terms_d = n_terms;
    case (state)
      IDLE: begin
        if (start) begin
          acc_d     = bias;
          cnt_d     = '0;
          n_terms_d = num_terms;
          state_d   = (num_terms == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = sum_sat;
          cnt_d = cnt + CNT_BIT'(1);
          if (last_term) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops alongside it.
  always_comb begin
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign psum_out  = acc;

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - randomized self-checking bench for psum_accumulator
module tb_psum_accumulator;
  localparam int PB = 8;
  localparam int PS = 25;
  localparam int CB = 10;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, out_ready;
  logic [CB-1:0] num_terms;
  logic [PS-1:0] bias;
  logic [PB-1:0] act_in, weight_in;
  logic          in_ready, out_valid, busy;
  logic [PS-1:0] psum_out;

  int checks = 0;
  int errors = 0;
  int acts[64];
  int wts[64];

  psum_accumulator #(.PARAM_BIT(PB), .PARTIAL_BIT(PS), .CNT_BIT(CB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in), .weight_in(weight_in),
    .psum_out(psum_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [PS-1:0] model_sum(input logic signed [PS-1:0] b, input int n);
    longint acc = b;
    longint hi  = (longint'(1) <<< (PS - 1)) - 1;
    longint lo  = -(longint'(1) <<< (PS - 1));
    for (int i = 0; i < n; i++) begin
      acc += longint'(acts[i]) * longint'(wts[i]);
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
    end
    return acc[PS-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sum(input logic [PS-1:0] b, input int n, input int max_gap,
                         input int ready_delay, input bit start_at_handshake,
                         output logic [PS-1:0] got, output bit proto_ok, output bit no_timeout);
    int guard;
    proto_ok   = 1'b1;
    no_timeout = 1'b1;
    start = 1'b1; bias = b; num_terms = CB'(n);
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
      in_valid  = 1'b1;
      act_in    = acts[i][PB-1:0];
      weight_in = wts[i][PB-1:0];
      guard = 0;
      while (in_ready !== 1'b1 && guard < 20) begin
        tick();
        guard++;
      end
      if (in_ready !== 1'b1) no_timeout = 1'b0;
      tick();
      if (out_valid !== (i == n - 1)) proto_ok = 1'b0;
    end
    in_valid = 1'b0;
    if (n == 0 && (out_valid !== 1'b1 || in_ready !== 1'b0)) proto_ok = 1'b0;
    got = psum_out;
    repeat (ready_delay) begin
      tick();
      if (out_valid !== 1'b1 || psum_out !== got) proto_ok = 1'b0;
    end
    out_ready = 1'b1;
    if (start_at_handshake) begin
      start = 1'b1; bias = ~b; num_terms = CB'(3);
    end
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) proto_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    num_terms = '0; bias = '0; act_in = '0; weight_in = '0;
    repeat (3) tick();
    checks++;
    if ({psum_out, out_valid, in_ready, busy} !== {{PS{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL reset_outputs: got psum=%0d ov=%b ir=%b busy=%b expected all 0",
               $signed(psum_out), out_valid, in_ready, busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [PS-1:0] got;
    bit pok, nto;
    acts[0] = 2;   wts[0] = 3;
    acts[1] = -4;  wts[1] = 5;
    acts[2] = 127; wts[2] = -128;
    run_sum('0, 3, 0, 0, 1'b0, got, pok, nto);
    checks++;
    if (got !== PS'(-16270)) begin
      errors++;
      $display("FAIL basic_sum: got %0d expected %0d", $signed(got), -16270);
    end
    checks++;
    if (!(pok && nto)) begin
      errors++;
      $display("FAIL basic_protocol: got proto=%b nto=%b expected 1 1", pok, nto);
    end
  endtask

  task automatic test_zero_terms();
    start = 1'b1; bias = PS'(100); num_terms = '0;
    tick();
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || psum_out !== PS'(100)) begin
      errors++;
      $display("FAIL zero_terms: got ov=%b ir=%b psum=%0d expected 1 0 100",
               out_valid, in_ready, $signed(psum_out));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_terms_idle: got busy=%b ov=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_saturation();
    logic [PS-1:0] got;
    bit pok, nto;
    acts[0] = 127; wts[0] = 127; acts[1] = 127; wts[1] = 127;
    run_sum(PS'(16777000), 2, 0, 0, 1'b0, got, pok, nto);
    checks++;
    if (got !== PS'(16777215) || !pok || !nto) begin
      errors++;
      $display("FAIL sat_pos: got %0d proto=%b expected %0d proto=1", $signed(got), pok, 16777215);
    end
    acts[0] = -128; wts[0] = 127; acts[1] = -128; wts[1] = 127;
    run_sum(PS'(-16777000), 2, 0, 0, 1'b0, got, pok, nto);
    checks++;
    if (got !== PS'(-16777216) || !pok || !nto) begin
      errors++;
      $display("FAIL sat_neg: got %0d proto=%b expected %0d proto=1", $signed(got), pok, -16777216);
    end
  endtask

  task automatic test_stall();
    bit gap_ok = 1'b1;
    bit hold_ok = 1'b1;
    start = 1'b1; bias = PS'(7); num_terms = CB'(2);
    tick();
    start = 1'b0;
    in_valid = 1'b1; act_in = PB'(3); weight_in = PB'(-5);
    tick();
    in_valid = 1'b0;
    repeat (5) begin
      tick();
      if (psum_out !== PS'(-8) || in_ready !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0)
        gap_ok = 1'b0;
    end
    checks++;
    if (!gap_ok) begin
      errors++;
      $display("FAIL stall_gap: got psum=%0d ir=%b ov=%b expected -8 1 0",
               $signed(psum_out), in_ready, out_valid);
    end
    in_valid = 1'b1; act_in = PB'(10); weight_in = PB'(10);
    tick();
    in_valid = 1'b0;
    repeat (4) begin
      if (out_valid !== 1'b1 || psum_out !== PS'(92)) hold_ok = 1'b0;
      tick();
    end
    checks++;
    if (!hold_ok || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: got ov=%b psum=%0d expected 1 92", out_valid, $signed(psum_out));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || psum_out !== PS'(92)) begin
      errors++;
      $display("FAIL stall_release: got busy=%b ov=%b psum=%0d expected 0 0 92",
               busy, out_valid, $signed(psum_out));
    end
  endtask

  task automatic test_restart_reset();
    logic [PS-1:0] exp1, got;
    bit quiet = 1'b1;
    bit pok, nto;
    for (int i = 0; i < 4; i++) begin
      acts[i] = int'($urandom_range(0, 255)) - 128;
      wts[i]  = int'($urandom_range(0, 255)) - 128;
    end
    exp1 = model_sum(PS'(50), 1);
    start = 1'b1; bias = PS'(50); num_terms = CB'(4);
    tick();
    start = 1'b0;
    in_valid = 1'b1; act_in = acts[0][PB-1:0]; weight_in = wts[0][PB-1:0];
    tick();
    in_valid = 1'b0;
    start = 1'b1; bias = PS'(999); num_terms = '0;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || psum_out !== exp1) begin
      errors++;
      $display("FAIL restart_ignored: got busy=%b ir=%b ov=%b psum=%0d expected 1 1 0 %0d",
               busy, in_ready, out_valid, $signed(psum_out), $signed(exp1));
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({psum_out, out_valid, in_ready, busy} !== {{PS{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL midrun_reset: got psum=%0d ov=%b ir=%b busy=%b expected all 0",
               $signed(psum_out), out_valid, in_ready, busy);
    end
    in_valid = 1'b1;
    repeat (4) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL reset_quiet: got ov=%b busy=%b expected 0 0", out_valid, busy);
    end
    run_sum(PS'(-3), 4, 1, 0, 1'b0, got, pok, nto);
    checks++;
    if (got !== model_sum(PS'(-3), 4) || !pok || !nto) begin
      errors++;
      $display("FAIL after_reset_sum: got %0d proto=%b expected %0d proto=1",
               $signed(got), pok, $signed(model_sum(PS'(-3), 4)));
    end
  endtask

  task automatic test_back_to_back();
    logic [PS-1:0] got1, got2;
    bit pok1, nto1, pok2, nto2;
    for (int i = 0; i < 5; i++) begin
      acts[i] = int'($urandom_range(0, 255)) - 128;
      wts[i]  = int'($urandom_range(0, 255)) - 128;
    end
    run_sum(PS'(1000), 5, 0, 2, 1'b1, got1, pok1, nto1);
    checks++;
    if (got1 !== model_sum(PS'(1000), 5) || !pok1 || !nto1) begin
      errors++;
      $display("FAIL b2b_first: got %0d proto=%b expected %0d proto=1",
               $signed(got1), pok1, $signed(model_sum(PS'(1000), 5)));
    end
    run_sum(PS'(-2000), 3, 0, 0, 1'b0, got2, pok2, nto2);
    checks++;
    if (got2 !== model_sum(PS'(-2000), 3) || !pok2 || !nto2) begin
      errors++;
      $display("FAIL b2b_second: got %0d proto=%b expected %0d proto=1",
               $signed(got2), pok2, $signed(model_sum(PS'(-2000), 3)));
    end
  endtask

  task automatic test_random();
    logic [PS-1:0] b, got, exp;
    bit pok, nto;
    int n, r;
    for (int t = 0; t < 30; t++) begin
      n = int'($urandom_range(0, 12));
      r = int'($urandom);
      case (t % 3)
        0: b = r[PS-1:0];
        1: b = PS'(16777215 - int'($urandom_range(0, 50000)));
        default: b = PS'(-16777216 + int'($urandom_range(0, 50000)));
      endcase
      for (int i = 0; i < n; i++) begin
        acts[i] = int'($urandom_range(0, 255)) - 128;
        wts[i]  = int'($urandom_range(0, 255)) - 128;
      end
      exp = model_sum(b, n);
      run_sum(b, n, 3, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got, pok, nto);
      checks++;
      if (got !== exp || !pok || !nto) begin
        errors++;
        $display("FAIL random_%0d: got %0d proto=%b nto=%b expected %0d proto=1 nto=1",
                 t, $signed(got), pok, nto, $signed(exp));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_terms();
    test_saturation();
    test_stall();
    test_restart_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter PARAM_BIT, default 8, signed activation/weight operand width.
REQ-002 SHALL have parameter PARTIAL_BIT, default 25, signed partial-sum width; it matches the activation quantizer input width.
REQ-003 SHALL have parameter CNT_BIT, default 10, width of the term counter and num_terms.
REQ-004 SHALL have port clk  input  1  clock, all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a new partial sum.
REQ-007 SHALL have port num_terms  input  CNT_BIT  unsigned product count for this sum, sampled on accepted start.
REQ-008 SHALL have port bias  input  PARTIAL_BIT  signed initial accumulator value, sampled on accepted start.
REQ-009 SHALL have port in_valid  input  1  act_in/weight_in pair valid.
REQ-010 SHALL have port in_ready  output  1  block accepts a pair this cycle.
REQ-011 SHALL have port act_in  input  PARAM_BIT  signed activation.
REQ-012 SHALL have port weight_in  input  PARAM_BIT  signed weight.
REQ-013 SHALL have port psum_out  output  PARTIAL_BIT  signed finished partial sum.
REQ-014 SHALL have port out_valid  output  1  psum_out valid.
REQ-015 SHALL have port out_ready  input  1  downstream quantizer accepts psum_out.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, DONE, all state and outputs registered.
REQ-018 IDLE: start=1 SHALL load acc<=bias, cnt<=0, latch num_terms; next state ACCUM, or DONE if num_terms==0.
REQ-019 start SHALL be ignored in ACCUM and DONE.
REQ-020 in_ready SHALL be 1 only in ACCUM; a transfer is in_valid & in_ready.
REQ-021 Each transfer SHALL compute the full-precision signed product act_in*weight_in (2*PARAM_BIT bits), sign-extend it to PARTIAL_BIT+1 bits, and add it to acc.
REQ-022 Sums above 2^(PARTIAL_BIT-1)-1 SHALL saturate to that value; sums below -2^(PARTIAL_BIT-1) SHALL saturate to that value; no wrap-around.
REQ-023 Each transfer SHALL increment cnt; the transfer with cnt==num_terms-1 SHALL move the FSM to DONE.
REQ-024 Cycles in ACCUM without in_valid SHALL leave acc and cnt unchanged; the FSM stalls indefinitely.
REQ-025 DONE SHALL drive out_valid=1 and psum_out=acc, held stable until out_ready=1.
REQ-026 DONE with out_ready=1 SHALL return to IDLE next cycle; a start in that same cycle is ignored.
REQ-027 Latency: out_valid SHALL rise on the clock edge that registers the last transfer, i.e. first visible the cycle after the last transfer, or the cycle after start when num_terms==0.
REQ-028 psum_out SHALL equal acc in every state; only out_valid qualifies it.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force state IDLE, acc=0, cnt=0, latched num_terms=0; out_valid=0, psum_out=0, in_ready=0, busy=0.
REQ-030 Reset asserted mid-ACCUM or mid-DONE SHALL discard the partial sum with no out_valid pulse; the next start behaves as after power-up.

Verification
REQ-031 bias=0, num_terms=3, pairs (2,3),(-4,5),(127,-128) with in_valid continuous -> out_valid the cycle after the 3rd transfer, psum_out=6-20-16256=-16270.
REQ-032 bias=100, num_terms=0 -> out_valid the cycle after start, psum_out=100, in_ready never asserted.
REQ-033 bias=16777000, num_terms=2, pairs (127,127),(127,127) -> psum_out=16777215 (positive saturation); with bias=-16777000 and pairs (-128,127),(-128,127) -> psum_out=-16777216.
REQ-034 num_terms=2, pair 1 sent, in_valid low 5 cycles, pair 2 sent; out_ready low 4 cycles in DONE -> acc unchanged during the gap; psum_out/out_valid stable for 4 cycles, then IDLE one cycle after out_ready=1.
REQ-035 start again in ACCUM after 1 of 4 transfers, then rst_n=0 one cycle -> second start ignored; after reset, outputs 0, state IDLE, no out_valid produced.
REQ-036 Back-to-back: start asserted the cycle after handshake completes (state IDLE) -> new sum begins with the new bias; no carry-over from the previous acc.
